// File: rtl/serv_alu_digit.sv
// Digit-serial SERV ALU: W bits per cycle, LSB digit first, N = XLEN/W cycles per phase.
// Init phase buffers rs1/shamt and evaluates the compare; execute phase streams rd.
module serv_alu_digit #(
  parameter int W    = 1,
  parameter int XLEN = 32
) (
  input  logic         clk,
  input  logic         i_rst_n,
  input  logic         i_init,
  input  logic         i_en,
  input  logic [W-1:0] i_rs1,
  input  logic [W-1:0] i_op_b,
  input  logic         i_sub,
  input  logic [1:0]   i_bool_op,
  input  logic         i_cmp_eq,
  input  logic         i_cmp_neg,
  input  logic         i_cmp_uns,
  input  logic         i_sh_right,
  input  logic         i_sh_signed,
  input  logic [1:0]   i_rd_sel,
  output logic         o_cmp,
  output logic [W-1:0] o_rd
);
  localparam int N  = XLEN / W;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  logic [CW-1:0]   cnt;
  logic            carry, eq, lt;
  logic [4:0]      shamt;
  logic [XLEN-1:0] rs1_buf;

  logic run, ex, first, last;
  assign run   = i_init | i_en;
  assign ex    = i_en & ~i_init;
  assign first = (cnt == '0);
  assign last  = (cnt == CW'(N - 1));

  // Flipping both digit MSBs on the last signed digit turns the unsigned
  // digit compare into a two's-complement compare of the whole word.
  logic [W-1:0] msb_mask, da, db;
  logic         eq_nxt, lt_nxt;
  assign msb_mask = W'(last & ~i_cmp_uns) << (W - 1);
  assign da       = i_rs1 ^ msb_mask;
  assign db       = i_op_b ^ msb_mask;
  assign eq_nxt   = (first | eq) & (i_rs1 == i_op_b);
  assign lt_nxt   = (da < db) | ((da == db) & ~first & lt);

  logic [W-1:0] b_add;
  logic         cin;
  logic [W:0]   sum_w;
  assign b_add = i_sub ? ~i_op_b : i_op_b;
  assign cin   = first ? i_sub : carry;
  assign sum_w = {1'b0, i_rs1} + {1'b0, b_add} + {{W{1'b0}}, cin};

  logic              fill;
  logic [2*XLEN-1:0] sr_ext;
  logic [XLEN-1:0]   sh_res;
  logic [W-1:0]      sh_dig, bool_dig;
  assign fill   = i_sh_signed & rs1_buf[XLEN-1];
  assign sr_ext = {{XLEN{fill}}, rs1_buf} >> shamt;
  assign sh_res = i_sh_right ? sr_ext[XLEN-1:0] : (rs1_buf << shamt);

  always_comb begin
    sh_dig = '0;
    for (int d = 0; d < N; d++)
      if (cnt == CW'(d)) sh_dig = sh_res[d*W +: W];
  end

  always_comb begin
    case (i_bool_op)
      2'b00:   bool_dig = i_rs1 ^ i_op_b;
      2'b01:   bool_dig = ~(i_rs1 ^ i_op_b);
      2'b10:   bool_dig = i_rs1 | i_op_b;
      default: bool_dig = i_rs1 & i_op_b;
    endcase
  end

  always_comb begin
    o_rd = '0;
    if (i_rst_n && ex) begin
      case (i_rd_sel)
        2'b00:   o_rd = sum_w[W-1:0];
        2'b01:   o_rd = sh_dig;
        2'b10:   o_rd = first ? W'(o_cmp) : '0;
        default: o_rd = bool_dig;
      endcase
    end
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt     <= '0;
      carry   <= 1'b0;
      eq      <= 1'b0;
      lt      <= 1'b0;
      shamt   <= '0;
      rs1_buf <= '0;
      o_cmp   <= 1'b0;
    end else begin
      cnt   <= (run && !last) ? cnt + 1'b1 : '0;
      carry <= ex ? sum_w[W] : 1'b0;
      if (i_init) begin
        eq <= eq_nxt;
        lt <= lt_nxt;
        for (int d = 0; d < N; d++)
          if (cnt == CW'(d)) rs1_buf[d*W +: W] <= i_rs1;
        // shamt bit j lives in digit j/W at position j%W
        for (int j = 0; j < 5; j++)
          if ((j / W) < N && cnt == CW'(j / W)) shamt[j] <= i_op_b[j % W];
        if (last) o_cmp <= i_cmp_neg ^ (i_cmp_eq ? eq_nxt : lt_nxt);
      end
    end
  end
endmodule

// File: tb/tb_serv_alu_digit.sv
// Directed bench: five ALU instances (W = 1,2,4,8,16) share operand/control
// signals; each phase strobes only the instance under test.
module tb_serv_alu_digit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [4:0]  init_v = '0, en_v = '0, cmp_v;
  logic [31:0] sh_a = '0, sh_b = '0;
  logic        sub = 0, cmp_eq = 0, cmp_neg = 0, cmp_uns = 0, sh_right = 0, sh_signed = 0;
  logic [1:0]  bool_op = '0, rd_sel = '0;
  logic [4:0][31:0] rd_all;
  logic [31:0] res;
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 5; g++) begin : g_dut
    localparam int WG = 1 << g;
    logic [WG-1:0] rd;
    serv_alu_digit #(.W(WG), .XLEN(32)) u_dut (
      .clk(clk), .i_rst_n(rst_n), .i_init(init_v[g]), .i_en(en_v[g]),
      .i_rs1(sh_a[WG-1:0]), .i_op_b(sh_b[WG-1:0]), .i_sub(sub),
      .i_bool_op(bool_op), .i_cmp_eq(cmp_eq), .i_cmp_neg(cmp_neg),
      .i_cmp_uns(cmp_uns), .i_sh_right(sh_right), .i_sh_signed(sh_signed),
      .i_rd_sel(rd_sel), .o_cmp(cmp_v[g]), .o_rd(rd)
    );
    assign rd_all[g] = 32'(rd);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One full N-cycle phase on instance idx, collecting the rd digit stream.
  task automatic run_phase(input int idx, input bit do_init, input bit do_en,
                           input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] r);
    int w = 1 << idx;
    r = '0;
    for (int k = 0; k < 32 / w; k++) begin
      @(negedge clk);
      sh_a = a >> (k * w);
      sh_b = b >> (k * w);
      init_v[idx] = do_init;
      en_v[idx]   = do_en;
      #1;
      r = r | (rd_all[idx] << (k * w));
    end
    @(negedge clk);
    init_v = '0; en_v = '0; sh_a = '0; sh_b = '0;
  endtask

  initial begin
    // reset state: outputs forced low even with execute strobes and live operands
    #1 rst_n = 1'b0;
    en_v = '1; rd_sel = 2'b11; bool_op = 2'b00; sh_a = '1;
    #2;
    chk("rst_rd", rd_all[0] | rd_all[1] | rd_all[2] | rd_all[3] | rd_all[4], 32'h0);
    chk("rst_cmp", {27'h0, cmp_v}, 32'h0);
    en_v = '0; sh_a = '0;
    @(negedge clk); rst_n = 1'b1;

    // W=1 add, including carry chain that overflows and must not leak
    rd_sel = 2'b00; sub = 0;
    run_phase(0, 0, 1, 32'h7FFFFFFF, 32'h1, res); chk("w1_add", res, 32'h80000000);
    run_phase(0, 0, 1, 32'hFFFFFFFF, 32'h1, res); chk("w1_add_ovf", res, 32'h0);
    run_phase(0, 0, 1, 32'h0, 32'h0, res);        chk("w1_carry_clr", res, 32'h0);

    // W=4 sub and signed SLT
    sub = 1;
    run_phase(2, 0, 1, 32'd5, 32'd7, res); chk("w4_sub", res, 32'hFFFFFFFE);
    sub = 0; cmp_eq = 0; cmp_uns = 0; cmp_neg = 0;
    run_phase(2, 1, 0, 32'd5, 32'd7, res); chk("w4_slt_cmp", {31'h0, cmp_v[2]}, 32'h1);
    rd_sel = 2'b10;
    run_phase(2, 0, 1, 32'h0, 32'h0, res); chk("w4_slt_rd", res, 32'h1);

    // W=8 compares
    cmp_uns = 1;
    run_phase(3, 1, 0, 32'hFFFFFFFF, 32'h1, res); chk("w8_ltu", {31'h0, cmp_v[3]}, 32'h0);
    cmp_uns = 0;
    run_phase(3, 1, 0, 32'hFFFFFFFF, 32'h1, res); chk("w8_lt", {31'h0, cmp_v[3]}, 32'h1);
    cmp_eq = 1; cmp_neg = 1;
    run_phase(3, 1, 0, 32'h12345678, 32'h12345678, res); chk("w8_ne_eq", {31'h0, cmp_v[3]}, 32'h0);
    run_phase(3, 1, 0, 32'h12345678, 32'h12345679, res); chk("w8_ne_diff", {31'h0, cmp_v[3]}, 32'h1);
    cmp_eq = 0; cmp_neg = 0;

    // W=2 shifts from the init-captured buffer
    run_phase(1, 1, 0, 32'h80000010, 32'd4, res);
    rd_sel = 2'b01; sh_right = 1; sh_signed = 1;
    run_phase(1, 0, 1, 32'h0, 32'h0, res); chk("w2_sra", res, 32'hF8000001);
    sh_signed = 0;
    run_phase(1, 0, 1, 32'h0, 32'h0, res); chk("w2_srl", res, 32'h08000001);
    sh_right = 0;
    run_phase(1, 0, 1, 32'h0, 32'h0, res); chk("w2_sll4", res, 32'h00000100);
    run_phase(1, 1, 0, 32'h80000010, 32'd31, res);
    run_phase(1, 0, 1, 32'h0, 32'h0, res); chk("w2_sll31", res, 32'h0);
    run_phase(1, 1, 0, 32'h80000010, 32'd0, res);
    sh_right = 1; sh_signed = 1;
    run_phase(1, 0, 1, 32'h0, 32'h0, res); chk("w2_sh0", res, 32'h80000010);
    sh_right = 0; sh_signed = 0;

    // W=16 boolean ops, then init+en together must yield zero
    rd_sel = 2'b11;
    bool_op = 2'b00; run_phase(4, 0, 1, 32'hF0F0A5A5, 32'h0FF0FFFF, res); chk("w16_xor", res, 32'hFF005A5A);
    bool_op = 2'b01; run_phase(4, 0, 1, 32'hF0F0A5A5, 32'h0FF0FFFF, res); chk("w16_xnor", res, 32'h00FFA5A5);
    bool_op = 2'b10; run_phase(4, 0, 1, 32'hF0F0A5A5, 32'h0FF0FFFF, res); chk("w16_or", res, 32'hFFF0FFFF);
    bool_op = 2'b11; run_phase(4, 0, 1, 32'hF0F0A5A5, 32'h0FF0FFFF, res); chk("w16_and", res, 32'h00F0A5A5);
    run_phase(4, 1, 1, 32'hF0F0A5A5, 32'h0FF0FFFF, res); chk("w16_both", res, 32'h0);

    // W=1 reset mid-init, then a clean eq compare
    cmp_eq = 1; cmp_neg = 0;
    run_phase(0, 1, 0, 32'd5, 32'd5, res); chk("w1_eq_pre", {31'h0, cmp_v[0]}, 32'h1);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      sh_a = 32'd9 >> k; sh_b = 32'd9 >> k; init_v[0] = 1;
    end
    @(negedge clk);
    rst_n = 0; init_v[0] = 0; en_v[0] = 1; rd_sel = 2'b00; sh_a = 32'h1; sh_b = 32'h0;
    #1;
    chk("w1_rst_cmp", {31'h0, cmp_v[0]}, 32'h0);
    chk("w1_rst_rd", rd_all[0], 32'h0);
    @(negedge clk);
    en_v = '0; sh_a = '0;
    @(negedge clk); rst_n = 1;
    run_phase(0, 1, 0, 32'd3, 32'd3, res); chk("w1_eq_post", {31'h0, cmp_v[0]}, 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
